// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port fixed-latency memory between the fetch and data ports.
// Data has fixed priority; a starvation counter forces fetch through after STARVE_MAX data wins.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MEM_LAT = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_n;
    logic [LW-1:0] lat_cnt, lat_n;
    logic [SW-1:0] starve_cnt, starve_n;
    logic owner_d, we_q, done, window, unused_ok;
    logic [DW-1:0] if_q, d_q;

    if (MEM_LAT < 1) begin : g_lat_chk
        $error("mem_arbiter: MEM_LAT must be >= 1");
    end
    if (STARVE_MAX < 1) begin : g_starve_chk
        $error("mem_arbiter: STARVE_MAX must be >= 1");
    end

    assign unused_ok = ^{if_addr[1:0], d_addr[1:0]};
    assign done      = state == WAIT && lat_cnt == LW'(1);
    // reset gates the window so no grant escapes while the block is held in reset
    assign window    = reset && (state == IDLE || done);
    assign if_gnt    = window && if_req && (!d_req || starve_cnt == SW'(STARVE_MAX));
    assign d_gnt     = window && d_req && !if_gnt;
    assign if_rvalid = done && !owner_d;
    assign d_rvalid  = done && owner_d;
    assign if_rdata  = if_rvalid ? mem_rdata : if_q;
    assign d_rdata   = d_rvalid && !we_q ? mem_rdata : d_q;
    assign mem_en    = if_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr[AW-1:2] : if_gnt ? if_addr[AW-1:2] : '0;
    assign mem_wdata = mem_en ? d_wdata : '0;
    assign stall_if  = if_req && !if_gnt;

    always_comb begin
        state_n  = mem_en ? WAIT : done ? IDLE : state;
        lat_n    = mem_en ? LW'(MEM_LAT) : state == WAIT ? lat_cnt - LW'(1) : lat_cnt;
        starve_n = !if_req || if_gnt ? '0
                 : d_gnt && starve_cnt != SW'(STARVE_MAX) ? starve_cnt + SW'(1) : starve_cnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            if_q       <= '0;
            d_q        <= '0;
        end else begin
            state      <= state_n;
            lat_cnt    <= lat_n;
            starve_cnt <= starve_n;
            if (mem_en) begin
                owner_d <= d_gnt;
                we_q    <= mem_we;
            end
            if (if_rvalid) if_q <= mem_rdata;
            if (d_rvalid && !we_q) d_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (MEM_LAT=1/STARVE_MAX=4 and MEM_LAT=3/STARVE_MAX=2) checked
// cycle by cycle against a transaction-level model with a shadow memory.
module tb_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic if_req [2], d_req [2], d_we [2];
    logic [31:0] if_addr [2], d_addr [2], d_wdata [2];
    logic if_gnt [2], if_rvalid [2], d_gnt [2], d_rvalid [2], mem_en [2], mem_we [2], stall_if [2];
    logic [31:0] if_rdata [2], d_rdata [2], mem_wdata [2], mem_rdata [2];
    logic [29:0] mem_addr [2];
    logic [31:0] mem [2][256] = '{default: '0};
    logic [31:0] shadow [2][256] = '{default: '0};
    logic [31:0] pipe [2][3];
    int total = 0, bad = 0, cyc = 0;
    int free_at [2], starve [2], pend_due [2];
    bit pend [2], pend_d [2], pend_we [2], e_ig [2], e_dg [2];
    logic [31:0] pend_data [2], last_i [2], last_d [2];

    always #5 clock = ~clock;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u0 (
        .clock(clock), .reset(reset), .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .d_req(d_req[0]), .d_we(d_we[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]),
        .d_rdata(d_rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .stall_if(stall_if[0]));

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(2)) u1 (
        .clock(clock), .reset(reset), .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .d_req(d_req[1]), .d_we(d_we[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]),
        .d_rdata(d_rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .stall_if(stall_if[1]));

    // memory environment: read data captured at the access edge, outside valid slots it is noise
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
            pipe[k][0] <= mem_en[k] && !mem_we[k] ? mem[k][mem_addr[k][7:0]] : $urandom;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    function automatic int lat(int k);
        return k != 0 ? 3 : 1;
    endfunction

    function automatic int smax(int k);
        return k != 0 ? 2 : 4;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(int k);
        free_at[k] = 0;
        starve[k] = 0;
        pend[k] = 0;
        last_i[k] = '0;
        last_d[k] = '0;
        e_ig[k] = 0;
        e_dg[k] = 0;
    endtask

    task automatic check(int k);
        bit win, ig, dg, irv, drv;
        logic [31:0] ea;
        string p;
        p = k != 0 ? "L3" : "L1";
        if (!reset) begin
            chk({p, ".rst_ctl"}, {if_gnt[k], d_gnt[k], if_rvalid[k], d_rvalid[k], mem_en[k], mem_we[k]}, 0);
            chk({p, ".rst_mem"}, {mem_addr[k], mem_wdata[k]}, 0);
            chk({p, ".rst_rdata"}, {if_rdata[k], d_rdata[k]}, 0);
            e_ig[k] = 0;
            e_dg[k] = 0;
            return;
        end
        win = cyc >= free_at[k];
        ig = win && if_req[k] && (!d_req[k] || starve[k] == smax(k));
        dg = win && d_req[k] && !ig;
        irv = pend[k] && pend_due[k] == cyc && !pend_d[k];
        drv = pend[k] && pend_due[k] == cyc && pend_d[k];
        ea = dg ? d_addr[k] : ig ? if_addr[k] : '0;
        chk({p, ".gnt"}, {if_gnt[k], d_gnt[k]}, {ig, dg});
        chk({p, ".stall"}, stall_if[k], if_req[k] && !ig);
        chk({p, ".rvalid"}, {if_rvalid[k], d_rvalid[k]}, {irv, drv});
        chk({p, ".mem_ctl"}, {mem_en[k], mem_we[k]}, {ig || dg, dg && d_we[k]});
        chk({p, ".mem_addr"}, mem_addr[k], ea[31:2]);
        if (dg && d_we[k]) chk({p, ".mem_wdata"}, mem_wdata[k], d_wdata[k]);
        else if (!(ig || dg)) chk({p, ".mem_wdata_idle"}, mem_wdata[k], 0);
        chk({p, ".if_rdata"}, if_rdata[k], irv ? pend_data[k] : last_i[k]);
        chk({p, ".d_rdata"}, d_rdata[k], drv && !pend_we[k] ? pend_data[k] : last_d[k]);
        e_ig[k] = ig;
        e_dg[k] = dg;
    endtask

    task automatic advance(int k);
        int w;
        if (!reset) begin
            model_reset(k);
            return;
        end
        if (pend[k] && pend_due[k] == cyc) begin
            pend[k] = 0;
            if (!pend_d[k]) last_i[k] = pend_data[k];
            else if (!pend_we[k]) last_d[k] = pend_data[k];
        end
        if (e_ig[k] || e_dg[k]) begin
            w = e_dg[k] ? int'(d_addr[k][9:2]) : int'(if_addr[k][9:2]);
            pend[k] = 1;
            pend_due[k] = cyc + lat(k);
            pend_d[k] = e_dg[k];
            pend_we[k] = e_dg[k] && d_we[k];
            pend_data[k] = shadow[k][w];
            if (pend_we[k]) shadow[k][w] = d_wdata[k];
            free_at[k] = cyc + lat(k);
        end
        starve[k] = !if_req[k] || e_ig[k] ? 0 : e_dg[k] && starve[k] < smax(k) ? starve[k] + 1 : starve[k];
    endtask

    task automatic cycle();
        @(negedge clock);
        check(0);
        check(1);
        @(posedge clock);
        advance(0);
        advance(1);
        #1;
        cyc++;
    endtask

    task automatic set_i(int k, bit r, logic [31:0] a);
        if_req[k] = r;
        if_addr[k] = a;
    endtask

    task automatic set_d(int k, bit r, bit we, logic [31:0] a, logic [31:0] wd);
        d_req[k] = r;
        d_we[k] = we;
        d_addr[k] = a;
        d_wdata[k] = wd;
    endtask

    // requester that obeys the hold-until-grant rule, occasionally withdrawing a request
    task automatic rnd_drive(int k);
        if (e_ig[k] || !if_req[k]) set_i(k, $urandom_range(0, 3) != 0, $urandom);
        else if ($urandom_range(0, 19) == 0) if_req[k] = 0;
        if (e_dg[k] || !d_req[k]) set_d(k, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        else if ($urandom_range(0, 19) == 0) d_req[k] = 0;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        set_i(0, 1, 32'h8);
        set_d(0, 0, 0, 0, 0);
        set_i(1, 0, 0);
        set_d(1, 1, 0, 32'h4, 0);
        #2 reset = 1'b0;
        cycle();
        cycle();
        set_i(0, 0, 0);
        set_d(1, 0, 0, 0, 0);
        reset = 1'b1;
        cycle();

        set_d(0, 1, 1, 32'h10, 32'hDEADBEEF);
        #1 chk("wr.mem", {mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]}, {1'b1, 1'b1, 30'd4, 32'hDEADBEEF});
        cycle();
        set_d(0, 1, 1, 32'h8, 32'h12345678);
        #1 chk("wr.ack_b2b", {d_rvalid[0], d_gnt[0]}, 2'b11);
        cycle();
        set_d(0, 1, 0, 32'h10, 0);
        cycle();
        set_d(0, 0, 0, 0, 0);
        #1 chk("wr.readback", {d_rvalid[0], d_rdata[0]}, {1'b1, 32'hDEADBEEF});
        cycle();

        set_i(0, 1, 32'h8);
        #1 chk("fetch.gnt", {if_gnt[0], mem_addr[0], mem_we[0], stall_if[0]}, {1'b1, 30'd2, 1'b0, 1'b0});
        cycle();
        set_i(0, 0, 0);
        #1 chk("fetch.rvalid", {if_rvalid[0], if_rdata[0]}, {1'b1, 32'h12345678});
        cycle();
        #1 chk("fetch.hold", {if_rvalid[0], if_rdata[0]}, {1'b0, 32'h12345678});
        cycle();

        set_i(0, 1, 32'h20);
        set_d(0, 1, 0, 32'h10, 0);
        #1 chk("both.t", {d_gnt[0], if_gnt[0], stall_if[0]}, 3'b101);
        cycle();
        set_d(0, 0, 0, 0, 0);
        #1 chk("both.t1", {d_rvalid[0], if_gnt[0]}, 2'b11);
        cycle();
        set_i(0, 0, 0);
        #1 chk("both.t2", if_rvalid[0], 1'b1);
        cycle();

        set_i(0, 1, 32'h40);
        set_d(0, 1, 0, 32'h44, 0);
        for (int n = 0; n < 15; n++) begin
            #1 chk("starve.pattern", {d_gnt[0], if_gnt[0]}, n % 5 == 4 ? 2'b01 : 2'b10);
            cycle();
        end
        set_i(0, 0, 0);
        set_d(0, 0, 0, 0, 0);
        cycle();

        set_i(1, 1, 32'h100);
        for (int n = 0; n < 7; n++) begin
            #1 chk("lat3.pattern", {if_gnt[1], if_rvalid[1]}, {n % 3 == 0, n > 0 && n % 3 == 0});
            cycle();
        end
        reset = 1'b0;
        #1;
        check(0);
        check(1);
        model_reset(0);
        model_reset(1);
        cycle();
        cycle();
        reset = 1'b1;
        #1 chk("rst.first_gnt", {if_gnt[1], if_rvalid[1]}, 2'b10);
        cycle();
        set_i(1, 0, 0);
        for (int n = 0; n < 4; n++) cycle();

        for (int n = 0; n < 800; n++) begin
            rnd_drive(0);
            rnd_drive(1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
